// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract unit: adds two N-bit operands CHUNK bits per clock,
// rippling a registered carry between slices, with valid/ready on both sides.
module chunked_serial_adder #(
  parameter int unsigned N     = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow,
  output logic         zero
);

  localparam int unsigned NCH = N / CHUNK;
  localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NCH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [N-1:0]   opa_q, opa_d;
  logic [N-1:0]   opb_q, opb_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           zero_q, zero_d;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   slice;

  // Mux out the active slice of each operand and add it with the running carry.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (idx_q == IW'(i)) begin
        a_sl = opa_q[i*CHUNK +: CHUNK];
        b_sl = opb_q[i*CHUNK +: CHUNK];
      end
    end
    slice = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (idx_q == IW'(i)) sum_d[i*CHUNK +: CHUNK] = slice[CHUNK-1:0];
        end
        carry_d = slice[CHUNK];
        if (idx_q == LastIdx) begin
          cout_d  = slice[CHUNK];
          ovf_d   = (opa_q[N-1] == opb_q[N-1]) && (slice[CHUNK-1] != opa_q[N-1]);
          zero_d  = (sum_d == '0);
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: a CHUNK=8 and a CHUNK=32 instance checked every
// cycle against an arithmetic model, plus directed literal cases.
module tb_chunked_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], iv[2], ir[2], sb[2], ov[2], ordy[2], co[2], of[2], zr[2];
  logic [31:0] av[2], bv[2], sm[2];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  chunked_serial_adder #(.N(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
    .sub(sb[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]), .cout(co[0]),
    .overflow(of[0]), .zero(zr[0])
  );

  chunked_serial_adder #(.N(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .sub(sb[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]), .cout(co[1]),
    .overflow(of[1]), .zero(zr[1])
  );

  // Reference result {zero, overflow, cout, sum} from plain integer arithmetic.
  function automatic logic [34:0] ref_op(logic [31:0] x, logic [31:0] y, logic s);
    longint r;
    logic [31:0] res;
    logic c, o;
    if (s) begin
      r   = longint'($signed(x)) - longint'($signed(y));
      res = x - y;
      c   = (x >= y);
    end else begin
      r   = longint'($signed(x)) + longint'($signed(y));
      res = x + y;
      c   = ({1'b0, x} + {1'b0, y}) > 33'h0_FFFF_FFFF;
    end
    o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {(res == 32'd0), o, c, res};
  endfunction

  function automatic int nch(int u);
    return (u == 0) ? 4 : 1;
  endfunction

  // Timing model: 0 = idle, 1 = busy for nch cycles, 2 = result held.
  int          ph[2], cnt[2];
  logic [34:0] pend[2];
  logic [31:0] ms[2];
  logic        mc[2], mo[2], mz[2];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst[u]) begin
        ph[u] <= 0;
        cnt[u] <= 0;
        ms[u] <= '0;
        mc[u] <= 1'b0;
        mo[u] <= 1'b0;
        mz[u] <= 1'b0;
      end else begin
        case (ph[u])
          0: if (iv[u]) begin
            ph[u]   <= 1;
            cnt[u]  <= nch(u);
            pend[u] <= ref_op(av[u], bv[u], sb[u]);
          end
          1: if (cnt[u] == 1) begin
            ph[u] <= 2;
            {mz[u], mo[u], mc[u], ms[u]} <= pend[u];
          end else begin
            cnt[u] <= cnt[u] - 1;
          end
          default: if (ordy[u]) ph[u] <= 0;
        endcase
      end
    end
  end

  task automatic check(string nm, int u, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s unit%0d: got %h, required %h at %0t", nm, u, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model; sum is partially written while busy.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int u = 0; u < 2; u++) begin
          check("handshake", u, 64'({ir[u], ov[u]}), 64'({ph[u] == 0, ph[u] == 2}));
          check("flags", u, 64'({co[u], of[u], zr[u]}), 64'({mc[u], mo[u], mz[u]}));
          if (ph[u] != 1) check("sum", u, 64'(sm[u]), 64'(ms[u]));
        end
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic start_op(int u, logic [31:0] x, logic [31:0] y, logic s);
    int k = 0;
    iv[u] = 1'b1;
    av[u] = x;
    bv[u] = y;
    sb[u] = s;
    while (!ir[u] && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", u, 64'(k < 100), 64'd1);
    @(posedge clk);
    #1;
    iv[u] = 1'b0;
    av[u] = $urandom;
    bv[u] = $urandom;
    sb[u] = 1'($urandom);
  endtask

  // Waits for out_valid while scrambling the (ignored) operand inputs.
  task automatic finish_op(int u);
    int k = 0;
    @(negedge clk);
    while (!ov[u] && k < 100) begin
      av[u] = $urandom;
      bv[u] = $urandom;
      @(negedge clk);
      k++;
    end
    check("result_timeout", u, 64'(k < 100), 64'd1);
  endtask

  task automatic expect_res(int u, logic [31:0] s, logic c, logic o, logic z);
    check("lit_valid", u, 64'(ov[u]), 64'd1);
    check("lit_sum", u, 64'(sm[u]), 64'(s));
    check("lit_flags", u, 64'({co[u], of[u], zr[u]}), 64'({c, o, z}));
  endtask

  task automatic op_lit(int u, logic [31:0] x, logic [31:0] y, logic s,
                        logic [31:0] es, logic ec, logic eo, logic ez);
    start_op(u, x, y, s);
    finish_op(u);
    expect_res(u, es, ec, eo, ez);
    @(negedge clk);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; iv[u] = 1'b0; ordy[u] = 1'b1; sb[u] = 1'b0; av[u] = '0; bv[u] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("reset_state", u, 64'({ir[u], ov[u], co[u], of[u], zr[u]}), 64'b10000);
      check("reset_sum", u, 64'(sm[u]), 64'd0);
      rst[u] = 1'b0;
    end
    chk_en = 1'b1;
    @(negedge clk);

    op_lit(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    op_lit(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    op_lit(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    op_lit(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    op_lit(0, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    op_lit(0, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: result and flags hold, no new accept while out_ready is low.
    ordy[0] = 1'b0;
    start_op(0, 32'h1111_1111, 32'h2222_2222, 1'b0);
    finish_op(0);
    expect_res(0, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
    iv[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_ready_low", 0, 64'(ir[0]), 64'd0);
      expect_res(0, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    check("bp_release", 0, 64'({ir[0], ov[0]}), 64'b10);

    // Reset while slice 2 is being added.
    start_op(0, 32'h0000_AAAA, 32'h0000_5555, 1'b0);
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("abort_state", 0, 64'({ir[0], ov[0]}), 64'b10);
    check("abort_sum", 0, 64'(sm[0]), 64'd0);
    @(negedge clk);
    op_lit(0, 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);

    // Single-slice instance: result one cycle after accept.
    start_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    @(negedge clk);
    check("nch1_lat_early", 1, 64'(ov[1]), 64'd0);
    @(negedge clk);
    expect_res(1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);

    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 150; i++) begin
        ordy[u] = ($urandom_range(0, 3) != 0);
        start_op(u, pick(), pick(), 1'($urandom));
        finish_op(u);
        if (!ordy[u]) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          ordy[u] = 1'b1;
        end
        @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
